led_pattern_checker: RTL and testbench

// Receive-side checker for the 6-segment LED blink pattern driven by the board pattern generator.

---
 rtl/led_pattern_checker.sv | 169 ++++++++++++++++
 tb/tb_led_pattern_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_checker.sv
// led_pattern_checker: measures high/low run lengths of a blink pattern
// and tracks them against the expected 6-segment sequence.
module led_pattern_checker #(
  parameter int CNT_W = 8,
  parameter int SEG0  = 20,
  parameter int SEG1  = 10,
  parameter int SEG2  = 30,
  parameter int SEG3  = 30,
  parameter int SEG4  = 50,
  parameter int SEG5  = 11,
  parameter int TOL   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic             locked,
  output logic             period_pulse,
  output logic             err_pulse,
  output logic [7:0]       err_cnt,
  output logic [CNT_W-1:0] seg_len,
  output logic             seg_valid
);

  localparam int M01  = (SEG0 > SEG1) ? SEG0 : SEG1;
  localparam int M23  = (SEG2 > SEG3) ? SEG2 : SEG3;
  localparam int M45  = (SEG4 > SEG5) ? SEG4 : SEG5;
  localparam int M03  = (M01 > M23) ? M01 : M23;
  localparam int SMAX = (M03 > M45) ? M03 : M45;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO  = CNT_W'(SMAX + TOL + 1);
  localparam logic [CNT_W-1:0] S5   = CNT_W'(SEG5);
  localparam logic [CNT_W:0]   TOLX = (CNT_W+1)'(TOL);

  typedef enum logic {HUNT, TRACK} state_t;

  state_t           state, state_n;
  logic             s1, s2, prev;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             armed, armed_n;
  logic [2:0]       idx, idx_n;
  logic             locked_n, period_n, err_n, valid_n;
  logic [7:0]       err_cnt_n;
  logic [CNT_W-1:0] len_n;
  logic             edge_c, is5, hit, fault;

  // A saturated count is never a valid run length.
  function automatic logic fits(
    input logic [CNT_W-1:0] l,
    input logic [CNT_W-1:0] s
  );
    logic [CNT_W:0] tl, ts;
    tl = {1'b0, l} + TOLX;
    ts = {1'b0, s} + TOLX;
    return (l != CMAX) && (tl >= {1'b0, s})
        && ({1'b0, l} <= ts);
  endfunction

  function automatic logic [CNT_W-1:0] seg_of(
    input logic [2:0] i
  );
    case (i)
      3'd0:    seg_of = CNT_W'(SEG0);
      3'd1:    seg_of = CNT_W'(SEG1);
      3'd2:    seg_of = CNT_W'(SEG2);
      3'd3:    seg_of = CNT_W'(SEG3);
      3'd4:    seg_of = CNT_W'(SEG4);
      default: seg_of = CNT_W'(SEG5);
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    armed_n   = armed;
    idx_n     = idx;
    locked_n  = locked;
    err_cnt_n = err_cnt;
    len_n     = seg_len;
    period_n  = 1'b0;
    err_n     = 1'b0;
    valid_n   = 1'b0;
    fault     = 1'b0;
    edge_c    = s2 ^ prev;
    is5       = ~prev & fits(cnt, S5);
    hit       = fits(cnt, seg_of(idx));
    if (!en) begin
      state_n  = HUNT;
      locked_n = 1'b0;
      cnt_n    = '0;
      armed_n  = 1'b0;
      idx_n    = '0;
    end else begin
      if (edge_c)
        cnt_n = ONE;
      else if (cnt != CMAX)
        cnt_n = cnt + ONE;
      if (edge_c && armed) begin
        valid_n = 1'b1;
        len_n   = cnt;
      end
      // An edge that coincides with the timeout takes precedence.
      if (edge_c && !armed) begin
        armed_n = 1'b1;
      end else if (edge_c && state == HUNT) begin
        if (is5) begin
          state_n = TRACK;
          idx_n   = '0;
        end
      end else if (edge_c && hit) begin
        if (idx == 3'd5) begin
          idx_n    = '0;
          period_n = 1'b1;
          locked_n = 1'b1;
        end else begin
          idx_n = idx + 3'd1;
        end
      end else if (edge_c) begin
        fault   = 1'b1;
        state_n = is5 ? TRACK : HUNT;
        idx_n   = '0;
      end else if (state == TRACK && cnt >= TMO) begin
        fault   = 1'b1;
        state_n = HUNT;
      end
      if (fault) begin
        err_n    = 1'b1;
        locked_n = 1'b0;
        if (err_cnt != 8'hFF)
          err_cnt_n = err_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      prev         <= 1'b0;
      state        <= HUNT;
      cnt          <= '0;
      armed        <= 1'b0;
      idx          <= '0;
      locked       <= 1'b0;
      period_pulse <= 1'b0;
      err_pulse    <= 1'b0;
      err_cnt      <= '0;
      seg_len      <= '0;
      seg_valid    <= 1'b0;
    end else begin
      s1           <= din;
      s2           <= s1;
      prev         <= s2;
      state        <= state_n;
      cnt          <= cnt_n;
      armed        <= armed_n;
      idx          <= idx_n;
      locked       <= locked_n;
      period_pulse <= period_n;
      err_pulse    <= err_n;
      err_cnt      <= err_cnt_n;
      seg_len      <= len_n;
      seg_valid    <= valid_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_checker.sv
// tb_led_pattern_checker: table vectors, directed corners and random
// run sequences against a run-level reference model.
module tb_led_pattern_checker;

  logic clk = 1'b0;
  logic rst_n, en, din;
  logic lk0, pp0, ep0, sv0;
  logic lk1, pp1, ep1, sv1;
  logic [7:0] ec0, sl0, ec1, sl1;

  always #5 clk = ~clk;

  led_pattern_checker #(.TOL(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .locked(lk0), .period_pulse(pp0), .err_pulse(ep0),
    .err_cnt(ec0), .seg_len(sl0), .seg_valid(sv0)
  );

  led_pattern_checker #(.TOL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .locked(lk1), .period_pulse(pp1), .err_pulse(ep1),
    .err_cnt(ec1), .seg_len(sl1), .seg_valid(sv1)
  );

  typedef struct {
    bit v; int len; bit per; bit err; bit lk; int ecnt; int cyc;
  } rec_t;

  typedef struct {
    int len; bit per; bit err; bit lk; int ecnt;
  } vec_t;

  rec_t q0[$], q1[$], exq[$], gq[$];
  int   runs[$];
  int   seg[6] = '{20, 10, 30, 30, 50, 11};
  int   checks = 0, passed = 0, cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (sv0 || pp0 || ep0)
      q0.push_back('{sv0, int'(sl0), pp0, ep0, lk0, int'(ec0), cyc});
    if (sv1 || pp1 || ep1)
      q1.push_back('{sv1, int'(sl1), pp1, ep1, lk1, int'(ec1), cyc});
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic bit fits(input int l, input int s, input int tol);
    return l != 255 && l >= s - tol && l <= s + tol;
  endfunction

  // Run-level model: walks the list of run lengths and predicts every
  // strobe/pulse record the checker should emit.
  task automatic model(input int tol);
    bit trk, lk, hi, last, is5;
    int idx, ecnt, tmo, l;
    rec_t r;
    trk = 0; lk = 0; idx = 0; ecnt = 0; tmo = 50 + tol + 1;
    exq.delete();
    for (int i = 0; i < runs.size(); i++) begin
      l = runs[i];
      hi = (i % 2 == 0);
      last = (i == runs.size() - 1);
      if (trk && l > tmo + (last ? 6 : 0)) begin
        if (ecnt < 255) ecnt++;
        lk = 0; trk = 0;
        exq.push_back('{0, 0, 0, 1, 0, ecnt, 0});
      end
      if (!last && i > 0 || !last && i == 0) begin
        if (l > 255) l = 255;
        r = '{1, l, 0, 0, 0, 0, 0};
        is5 = !hi && fits(l, seg[5], tol);
        if (!trk) begin
          if (is5) begin trk = 1; idx = 0; end
        end else if (fits(l, seg[idx], tol)) begin
          if (idx == 5) begin idx = 0; r.per = 1; lk = 1; end
          else idx++;
        end else begin
          r.err = 1; lk = 0; idx = 0;
          if (ecnt < 255) ecnt++;
          trk = is5;
        end
        r.lk = lk; r.ecnt = ecnt;
        exq.push_back(r);
      end
    end
  endtask

  task automatic cmp_q(input string nm);
    chk({nm, " count"}, gq.size(), exq.size());
    for (int i = 0; i < gq.size() && i < exq.size(); i++) begin
      checks++;
      if (gq[i].v == exq[i].v && (!exq[i].v || gq[i].len == exq[i].len)
          && gq[i].per == exq[i].per && gq[i].err == exq[i].err
          && gq[i].lk == exq[i].lk && gq[i].ecnt == exq[i].ecnt)
        passed++;
      else
        $display("FAIL %s rec %0d: got v%0d len%0d per%0d err%0d lk%0d ec%0d expected v%0d len%0d per%0d err%0d lk%0d ec%0d",
          nm, i, gq[i].v, gq[i].len, gq[i].per, gq[i].err, gq[i].lk,
          gq[i].ecnt, exq[i].v, exq[i].len, exq[i].per, exq[i].err,
          exq[i].lk, exq[i].ecnt);
    end
  endtask

  task automatic drv(input bit lvl, input int n);
    din = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b1; din = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Runs alternate high/low starting high; the final run is left open.
  task automatic play(input string nm);
    q0.delete(); q1.delete();
    for (int i = 0; i < runs.size(); i++) drv(i % 2 == 0, runs[i]);
    #1;
    model(0); gq = q0; cmp_q({nm, " tol0"});
    model(1); gq = q1; cmp_q({nm, " tol1"});
  endtask

  initial begin
    vec_t tbl[30];
    int pc[$];
    int tv, te, ecb, b;

    for (int i = 0; i < 30; i++) begin
      tbl[i].len  = seg[i % 6];
      tbl[i].per  = (i == 11 || i == 23 || i == 29);
      tbl[i].err  = (i == 14);
      tbl[i].lk   = (i >= 11 && i <= 13) || i >= 23;
      tbl[i].ecnt = (i >= 14) ? 1 : 0;
    end
    tbl[14].len = 29;

    rst_n = 1'b1; en = 1'b1; din = 1'b0;
    #3 rst_n = 1'b0;
    #4 din = 1'b1;
    #4 din = 1'b0;
    #3 din = 1'b1;
    #1;
    chk("reset locked", lk0, 0);
    chk("reset period_pulse", pp0, 0);
    chk("reset err_pulse", ep0, 0);
    chk("reset err_cnt", ec0, 0);
    chk("reset seg_len", sl0, 0);
    chk("reset seg_valid", sv0, 0);
    chk("reset locked tol1", lk1, 0);
    @(negedge clk);
    do_reset();

    runs.delete();
    for (int i = 0; i < 30; i++) runs.push_back(tbl[i].len);
    runs.push_back(8);
    play("clean");
    chk("table count", q0.size(), 30);
    for (int i = 0; i < 30 && i < q0.size(); i++) begin
      checks++;
      if (q0[i].v && q0[i].len == tbl[i].len && q0[i].per == tbl[i].per
          && q0[i].err == tbl[i].err && q0[i].lk == tbl[i].lk
          && q0[i].ecnt == tbl[i].ecnt)
        passed++;
      else
        $display("FAIL table %0d: got len%0d per%0d err%0d lk%0d ec%0d expected len%0d per%0d err%0d lk%0d ec%0d",
          i, q0[i].len, q0[i].per, q0[i].err, q0[i].lk, q0[i].ecnt,
          tbl[i].len, tbl[i].per, tbl[i].err, tbl[i].lk, tbl[i].ecnt);
    end
    foreach (q0[i]) if (q0[i].per) pc.push_back(q0[i].cyc);
    chk("period pulses", pc.size(), 3);
    if (pc.size() >= 3) chk("period spacing", pc[2] - pc[1], 151);

    chk("locked before async reset", lk0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0; din = ~din;
    #1;
    chk("async reset locked", lk0, 0);
    chk("async reset err_cnt", ec0, 0);
    chk("async reset seg_len", sl0, 0);
    chk("async reset locked tol1", lk1, 0);
    @(negedge clk);
    do_reset();

    runs = '{20, 11, 21, 9, 31, 29, 49, 12, 21, 9, 31, 29, 49, 12, 8};
    play("tolerance");
    chk("tol1 locked", lk1, 1);
    chk("tol1 err_cnt", ec1, 0);
    chk("tol0 err_cnt", ec0, 1);
    if (q0.size() >= 3) chk("tol0 first err len", q0[2].len, 21);
    do_reset();

    runs = '{20, 10, 30, 30, 50, 11, 20, 10, 200};
    play("stuck");
    tv = -1; te = -1;
    foreach (q0[i]) if (q0[i].v) tv = q0[i].cyc; else if (q0[i].err) te = q0[i].cyc;
    chk("timeout delay tol0", te - tv, 51);
    tv = -1; te = -1;
    foreach (q1[i]) if (q1[i].v) tv = q1[i].cyc; else if (q1[i].err) te = q1[i].cyc;
    chk("timeout delay tol1", te - tv, 52);
    do_reset();

    runs.delete();
    runs.push_back(5);
    for (int i = 0; i < 300; i++) begin runs.push_back(11); runs.push_back(5); end
    runs.push_back(8);
    play("saturate");
    chk("err_cnt saturated", ec0, 255);
    do_reset();

    runs = '{20, 10, 30, 30, 50, 11, 20, 10, 30, 30, 50, 11, 10};
    play("en pre");
    chk("locked before en drop", lk0, 1);
    ecb = ec0;
    q0.delete();
    en = 1'b0;
    drv(1, 2);
    chk("en=0 locked", lk0, 0);
    drv(0, 4);
    drv(1, 4);
    chk("en=0 no pulses", q0.size(), 0);
    chk("en=0 err_cnt", ec0, ecb);
    en = 1'b1;
    drv(1, 5);
    runs = '{10, 30, 30, 50, 11, 20, 10, 30, 30, 50, 11};
    for (int i = 0; i < runs.size(); i++) drv(i % 2 == 1, runs[i]);
    drv(1, 8);
    chk("relock after en", lk0, 1);
    chk("err_cnt after en", ec0, ecb);
    do_reset();

    for (int r = 0; r < 4; r++) begin
      runs.delete();
      for (int i = 0; i < 36; i++) begin
        b = seg[i % 6];
        case ($urandom_range(0, 11))
          0: b = b + 1;
          1: b = b - 1;
          2: b = b + 2;
          3: b = $urandom_range(52, 70);
          4: if (r == 3) b = 300;
          default: ;
        endcase
        runs.push_back(b);
      end
      runs.push_back(8);
      play($sformatf("random%0d", r));
      do_reset();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
